// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single external memory port shared by fetch and data.
// Data wins by default; a bounded data-grant streak guarantees fetch forward progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_done,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_done,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_outside
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STARVE_LIM = STREAK_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                inst_done_q, inst_done_d;
  logic                data_done_q, data_done_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                grant_inst_s;

  // Fetch wins only when data is absent or data has used up its streak allowance.
  assign grant_inst_s = inst_req && (!data_req || (streak_q == STARVE_LIM));

  // Next-state logic for the transaction sequencer and its latched attributes.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          state_d   = ST_REQ;
          mem_req_d = 1'b1;
          if (grant_inst_s) begin
            owner_d     = OWN_INST;
            mem_we_d    = 1'b0;
            mem_addr_d  = inst_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            streak_d    = '0;
          end else begin
            owner_d     = OWN_DATA;
            mem_we_d    = data_we;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
            mem_wstrb_d = data_wstrb;
            // Streak only grows while fetch is actually being held off.
            if (!inst_req) begin
              streak_d = '0;
            end else if (streak_q == STARVE_LIM) begin
              streak_d = streak_q;
            end else begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_RESP;
          if (owner_q == OWN_INST) begin
            inst_rdata_d = mem_rdata;
            inst_done_d  = 1'b1;
          end else begin
            data_rdata_d = mem_rdata;
            data_done_d  = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      streak_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  // Stall must follow the requesters immediately, even while in reset.
  assign stallreq_outside = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder with programmable
// grant/rvalid delays plus a scoreboard of predicted transactions.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_done;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_wstrb = 4'h0;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stallreq_outside;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb_q[$];
  txn_t gnt_q[$];

  int   gnt_dly = 0;
  int   rv_dly = 0;
  logic force_rv = 1'b0;
  int   m_streak = 0;
  logic last_is_data = 1'b0;
  logic [31:0] last_inst_rd = 32'h0;
  logic [31:0] last_data_rd = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_done(data_done), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stallreq_outside(stallreq_outside)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory responder: grant after gnt_dly cycles of mem_req, rvalid rv_dly cycles after that.
  int          rs_phase = 0;
  int          rs_cnt = 0;
  logic [31:0] rs_addr = 32'h0;
  logic        rst_seen;
  always @(posedge clk) begin
    txn_t g;
    rst_seen = !rst_n;
    #2;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (rst_seen) begin
      rs_phase = 0;
      rs_cnt = 0;
    end else if (rs_phase == 0) begin
      if (mem_req) begin
        if (rs_cnt >= gnt_dly) begin
          mem_gnt = 1'b1;
          g.is_data = 1'b0; g.we = mem_we; g.addr = mem_addr;
          g.wdata = mem_wdata; g.wstrb = mem_wstrb; g.rdata = 32'h0;
          gnt_q.push_back(g);
          rs_addr = mem_addr;
          rs_phase = 1;
          rs_cnt = 0;
        end else begin
          rs_cnt++;
        end
      end
    end else begin
      if (rs_cnt >= rv_dly) begin
        mem_rvalid = 1'b1;
        mem_rdata = model(rs_addr);
        rs_phase = 0;
        rs_cnt = 0;
      end else begin
        rs_cnt++;
      end
    end
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Predict which request the next IDLE cycle grants and queue its expected result.
  task automatic predict();
    txn_t e;
    if (inst_req && (!data_req || m_streak == 4)) begin
      e.is_data = 1'b0; e.we = 1'b0; e.addr = inst_addr;
      e.wdata = 32'h0; e.wstrb = 4'h0; e.rdata = model(inst_addr);
      m_streak = 0;
    end else begin
      e.is_data = 1'b1; e.we = data_we; e.addr = data_addr;
      e.wdata = data_wdata; e.wstrb = data_wstrb; e.rdata = model(data_addr);
      m_streak = inst_req ? ((m_streak == 4) ? 4 : m_streak + 1) : 0;
    end
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    txn_t e;
    txn_t g;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("done_owner", 32'({inst_done, data_done}), e.is_data ? 32'd1 : 32'd2);
      chk("rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
      last_is_data = e.is_data;
      if (e.is_data) last_data_rd = e.rdata; else last_inst_rd = e.rdata;
      chk("gnt_logged", 32'(gnt_q.size() != 0), 32'd1);
      if (gnt_q.size() != 0) begin
        g = gnt_q.pop_front();
        chk("gnt_addr", g.addr, e.addr);
        chk("gnt_we", 32'(g.we), 32'(e.we));
        if (e.is_data) begin
          chk("gnt_wdata", g.wdata, e.wdata);
          chk("gnt_wstrb", 32'(g.wstrb), 32'(e.wstrb));
        end
      end
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(inst_done || data_done) && n < budget);
    if (!(inst_done || data_done)) chk("done_timeout", 32'(inst_done | data_done), 32'd1);
    else check_pop();
  endtask

  initial begin
    int n;
    int t_data;

    // Reset state; stall follows requests combinationally during reset.
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_dones", 32'({inst_done, data_done}), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    inst_req = 1'b1; #1;
    chk("rst_stall_follow", 32'(stallreq_outside), 32'd1);
    inst_req = 1'b0; #1;
    chk("rst_stall_drop", 32'(stallreq_outside), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single fetch with minimum latency.
    inst_addr = 32'h8000_0000; inst_req = 1'b1; predict(); #2;
    chk("t1_stall_c0", 32'(stallreq_outside), 32'd1);
    chk("t1_mem_req_c0", 32'(mem_req), 32'd0);
    step();
    chk("t1_mem_req_c1", 32'(mem_req), 32'd1);
    chk("t1_mem_addr_c1", mem_addr, 32'h8000_0000);
    #2 chk("t1_stall_c1", 32'(stallreq_outside), 32'd1);
    step();
    chk("t1_mem_req_c2", 32'(mem_req), 32'd0);
    chk("t1_done_c2", 32'(inst_done), 32'd0);
    #2 chk("t1_stall_c2", 32'(stallreq_outside), 32'd1);
    step();
    chk("t1_done_c3", 32'(inst_done), 32'd1);
    check_pop();
    #2 chk("t1_stall_c3", 32'(stallreq_outside), 32'd0);
    inst_req = 1'b0;
    step();
    chk("t1_done_c4", 32'(inst_done), 32'd0);

    // Simultaneous fetch and store: store first, fetch 4 cycles later.
    inst_addr = 32'h0000_1000; inst_req = 1'b1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0100;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
    predict();
    wait_done(20, n);
    chk("t2_store_lat", 32'(n), 32'd3);
    chk("t2_inst_waiting", 32'(inst_done), 32'd0);
    data_req = 1'b0; data_we = 1'b0; #1;
    chk("t2_inst_stall", 32'(stallreq_outside), 32'd1);
    predict();
    wait_done(20, n);
    chk("t2_fetch_gap", 32'(n), 32'd4);
    inst_req = 1'b0;
    step();

    // Starvation bound: 4 loads, 1 fetch, then again 4 loads, 1 fetch.
    inst_addr = 32'h0000_2000; inst_req = 1'b1;
    data_addr = 32'h0000_0300; data_we = 1'b0; data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      predict();
      wait_done(20, n);
      chk("t3_period", 32'(n), (i == 0) ? 32'd3 : 32'd4);
      chk("t3_order", 32'(last_is_data), (i == 4 || i == 9) ? 32'd0 : 32'd1);
      if (last_is_data) data_addr = data_addr + 32'd4;
      else inst_addr = inst_addr + 32'd4;
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // Delayed grant (3) and rvalid (5): done 11 cycles after sampling.
    gnt_dly = 3; rv_dly = 5;
    inst_addr = 32'h0000_4000; inst_req = 1'b1; predict();
    for (int c = 1; c <= 11; c++) begin
      step();
      chk("t4_mem_req", 32'(mem_req), (c <= 4) ? 32'd1 : 32'd0);
      if (c <= 4) chk("t4_addr_stable", mem_addr, 32'h0000_4000);
      chk("t4_done", 32'(inst_done), (c == 11) ? 32'd1 : 32'd0);
      if (c == 11) check_pop();
    end
    inst_req = 1'b0;
    step();
    chk("t4_done_one_cycle", 32'(inst_done), 32'd0);
    gnt_dly = 0; rv_dly = 0;

    // Spurious rvalid while idle.
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    step();
    chk("t5_no_done", 32'({inst_done, data_done}), 32'd0);
    chk("t5_inst_rdata", inst_rdata, last_inst_rd);
    chk("t5_data_rdata", data_rdata, last_data_rd);
    chk("t5_mem_req", 32'(mem_req), 32'd0);

    // Reset during WAIT abandons the fetch; a fresh fetch then completes.
    rv_dly = 3;
    inst_addr = 32'h0000_5000; inst_req = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    chk("t6_rst_dones", 32'({inst_done, data_done}), 32'd0);
    chk("t6_rst_inst_rdata", inst_rdata, 32'd0);
    chk("t6_rst_data_rdata", data_rdata, 32'd0);
    #2 chk("t6_rst_stall", 32'(stallreq_outside), 32'd1);
    gnt_q.delete();
    m_streak = 0;
    rst_n = 1'b1;
    predict();
    wait_done(30, n);
    chk("t6_refetch_lat", 32'(n), 32'd6);
    inst_req = 1'b0;
    step();
    chk("t6_done_cleared", 32'(inst_done), 32'd0);
    t_data = sb_q.size();
    chk("sb_drained", 32'(t_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
